ir_nec_transmitter: RTL and testbench
=====================================

// Module: ir_nec_transmitter
// PURPOSE
//  NEC-format IR transmitter, the send-side counterpart of the team's NEC receiver (same 50 MHz clock, custom code 16'h6B86).
//  On a send request, serialises {~key, key, CUSTOM_CODE} LSB-first behind a 9 ms / 4.5 ms leader, then a stop mark and gap.
//  Drives an active-low demodulated line (loopback-compatible with the receiver's IRDA_RXD) and a 38 kHz carrier-gated LED output.
// PARAMETERS
//  CUSTOM_CODE   16'h6B86  address code sent first (bits [15:0] of frame word)
//  LEAD_MARK_CYC 450000    9 ms leader mark (clk cycles)
//  LEAD_SPC_CYC  225000    4.5 ms leader space
//  BIT_MARK_CYC  28000     560 us mark per bit and stop mark
//  ZERO_SPC_CYC  28000     560 us space for logic 0
//  ONE_SPC_CYC   84500     1.69 ms space for logic 1
//  GAP_CYC       2000000   40 ms idle-high gap after stop mark, still busy
//  CARRIER_HALF  658       half-period of 38 kHz carrier (clk cycles)
// PORTS
//  clk       in   1  50 MHz clock
//  rst_n     in   1  asynchronous active-low reset
//  send      in   1  request; sampled only in IDLE
//  key_code  in   8  key byte; latched on accepted send
//  busy      out  1  high from cycle after accept through end of gap
//  done      out  1  one-cycle pulse on the cycle busy falls
//  ir_txd    out  1  demodulated level: 0 = mark, 1 = space/idle
//  ir_led    out  1  carrier during mark, 0 otherwise
// BEHAVIOUR
//  - Clock clk; reset rst_n asynchronous, active-low. Reset: state=IDLE, busy=0, done=0, ir_txd=1, ir_led=0, counters/shift reg=0.
//  - Frame word W = {~key_code, key_code, CUSTOM_CODE}; transmitted W[0] first, W[31] last.
//  - States: IDLE -> LEAD_MARK -> LEAD_SPACE -> BIT_MARK <-> BIT_SPACE (32 bits) -> STOP_MARK -> GAP -> IDLE.
//  - IDLE: send=1 latches W, enters LEAD_MARK; ir_txd goes 0 the next cycle. send while busy is ignored (no queueing).
//  - Each state lasts exactly its parameter count in cycles (duration counter, >=22 bits, cleared on every state entry).
//  - BIT_SPACE length chosen from current bit: 1 -> ONE_SPC_CYC, 0 -> ZERO_SPC_CYC; 6-bit bit index, shift right after each space.
//  - After bit 31's space: STOP_MARK (BIT_MARK_CYC), then GAP (ir_txd=1) for GAP_CYC, then IDLE with done=1 for 1 cycle.
//  - ir_txd and ir_led are registered; ir_txd=0 only in LEAD_MARK, BIT_MARK, STOP_MARK.
//  - Carrier: phase counter cleared at each mark entry; ir_led=1 first cycle of mark, toggles every CARRIER_HALF cycles; forced 0 outside marks.
//  - Frame length is key-independent (key and ~key contribute 8 ones): 3,399,000 cycles lead-start to stop-mark end; busy = 3,399,000 + GAP_CYC.
//  - Reset mid-frame: outputs return to reset values immediately; no done pulse; next send starts a fresh frame.
//  - send asserted on the same cycle done pulses (state IDLE) is accepted.
// TESTING
//  1 send, key=8'h45; ir_txd looped to team NEC receiver -> receiver data_valid=1, captured_code=8'h45; done once.
//  2 key=8'h00 and 8'hFF: measure ir_txd low 450000, high 225000, 32 marks of 28000, spaces 84500/28000 per W bit, stop 28000 -> exact counts.
//  3 send held high for whole frame, pulsed again mid-frame -> exactly one frame per IDLE acceptance; busy high 5,399,000 cycles.
//  4 rst_n low at cycle 1,000,000 of a frame -> ir_txd=1, ir_led=0, busy=0 same edge; new send produces clean full frame.
//  5 leader mark: count ir_led rising edges = 342, ir_led=0 throughout every space and GAP.
//  6 send on done cycle with key=8'h12 -> back-to-back frame accepted, receiver decodes 8'h12.

Source files
------------

// File: rtl/ir_nec_transmitter_if.sv
// Send-side bus of the NEC IR transmitter: request/key in, status and line levels out.
interface ir_nec_transmitter_if;
  logic       send;
  logic [7:0] key_code;
  logic       busy;
  logic       done;
  logic       ir_txd;
  logic       ir_led;

  modport master (
    output send, key_code,
    input  busy, done, ir_txd, ir_led
  );

  modport slave (
    input  send, key_code,
    output busy, done, ir_txd, ir_led
  );
endinterface

// File: rtl/ir_nec_transmitter.sv
// NEC-format IR transmitter. Serialises {~key, key, CUSTOM_CODE} LSB-first
// behind a leader, then a stop mark and an idle gap. Drives an active-low
// demodulated line (ir_txd) and a carrier-gated LED line (ir_led).
//
// state        | meaning
// S_IDLE       | waiting for send, line idle high
// S_LEAD_MARK  | 9 ms leader mark
// S_LEAD_SPACE | 4.5 ms leader space
// S_BIT_MARK   | 560 us mark preceding every data bit
// S_BIT_SPACE  | short (0) or long (1) space for the current bit
// S_STOP_MARK  | trailing 560 us mark after bit 31
// S_GAP        | idle-high gap, still busy; done pulses on exit
module ir_nec_transmitter #(
  parameter logic [15:0] CUSTOM_CODE   = 16'h6B86,
  parameter int unsigned LEAD_MARK_CYC = 450000,
  parameter int unsigned LEAD_SPC_CYC  = 225000,
  parameter int unsigned BIT_MARK_CYC  = 28000,
  parameter int unsigned ZERO_SPC_CYC  = 28000,
  parameter int unsigned ONE_SPC_CYC   = 84500,
  parameter int unsigned GAP_CYC       = 2000000,
  parameter int unsigned CARRIER_HALF  = 658
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ir_nec_transmitter_if.slave  bus
);

  localparam int CNT_W = 22;
  localparam int PH_W  = $clog2(CARRIER_HALF + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dur_m1;
  logic [31:0]      shift_q, shift_d;
  logic [5:0]       bit_idx_q, bit_idx_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             txd_q, txd_d;
  logic             led_q, led_d;
  logic             last_cyc;
  logic             mark_d;

  // State, duration counter, shift register and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      ph_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      txd_q     <= 1'b1;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      ph_q      <= ph_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      txd_q     <= txd_d;
      led_q     <= led_d;
    end
  end

  // Next-state sequencing plus output/carrier values for the coming cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    ph_d      = '0;
    led_d     = 1'b0;

    dur_m1 = '0;
    unique case (state_q)
      S_LEAD_MARK:  dur_m1 = CNT_W'(LEAD_MARK_CYC - 1);
      S_LEAD_SPACE: dur_m1 = CNT_W'(LEAD_SPC_CYC - 1);
      S_BIT_MARK:   dur_m1 = CNT_W'(BIT_MARK_CYC - 1);
      S_BIT_SPACE:  dur_m1 = shift_q[0] ? CNT_W'(ONE_SPC_CYC - 1) : CNT_W'(ZERO_SPC_CYC - 1);
      S_STOP_MARK:  dur_m1 = CNT_W'(BIT_MARK_CYC - 1);
      S_GAP:        dur_m1 = CNT_W'(GAP_CYC - 1);
      default:      dur_m1 = '0;
    endcase
    last_cyc = (cnt_q == dur_m1);

    unique case (state_q)
      S_IDLE: begin
        if (bus.send) begin
          state_d   = S_LEAD_MARK;
          shift_d   = {~bus.key_code, bus.key_code, CUSTOM_CODE};
          bit_idx_d = '0;
        end
      end
      S_LEAD_MARK:  if (last_cyc) state_d = S_LEAD_SPACE;
      S_LEAD_SPACE: if (last_cyc) state_d = S_BIT_MARK;
      S_BIT_MARK:   if (last_cyc) state_d = S_BIT_SPACE;
      S_BIT_SPACE: begin
        if (last_cyc) begin
          shift_d   = {1'b0, shift_q[31:1]};
          bit_idx_d = bit_idx_q + 6'd1;
          state_d   = (bit_idx_q == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
        end
      end
      S_STOP_MARK:  if (last_cyc) state_d = S_GAP;
      S_GAP:        if (last_cyc) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    // Every state starts counting from zero; IDLE holds the counter cleared.
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;

    mark_d = state_d inside {S_LEAD_MARK, S_BIT_MARK, S_STOP_MARK};
    txd_d  = ~mark_d;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_GAP) && (state_d == S_IDLE);

    // Carrier restarts high on every mark entry so each mark begins with a pulse.
    if (mark_d) begin
      if (state_d != state_q) begin
        ph_d  = '0;
        led_d = 1'b1;
      end else if (ph_q == PH_W'(CARRIER_HALF - 1)) begin
        ph_d  = '0;
        led_d = ~led_q;
      end else begin
        ph_d  = ph_q + PH_W'(1);
        led_d = led_q;
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ir_txd = txd_q;
  assign bus.ir_led = led_q;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Bench for ir_nec_transmitter with shortened timing. A line monitor measures
// every ir_txd run and the carrier, popping expected runs/words from queues
// that are filled when each send is driven.
module tb_ir_nec_transmitter;
  localparam int LM    = 90;
  localparam int LS    = 45;
  localparam int BM    = 6;
  localparam int ZS    = 6;
  localparam int OS    = 17;
  localparam int GAP   = 40;
  localparam int HALF  = 4;
  // 90 + 45 + 32*6 + 16*17 + 16*6 + 6 = 701 frame cycles, plus 40 gap
  localparam int FRAME_BUSY = 741;
  localparam int LIMIT      = 2000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ir_nec_transmitter_if ifc();

  ir_nec_transmitter #(
    .CUSTOM_CODE  (16'h6B86),
    .LEAD_MARK_CYC(LM),
    .LEAD_SPC_CYC (LS),
    .BIT_MARK_CYC (BM),
    .ZERO_SPC_CYC (ZS),
    .ONE_SPC_CYC  (OS),
    .GAP_CYC      (GAP),
    .CARRIER_HALF (HALF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {logic lvl; int len;} run_t;
  typedef struct {logic [7:0] key; logic [31:0] word; int busy_len;} vec_t;

  run_t        exp_run_q[$];
  logic [31:0] exp_word_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  bit          mon_en = 1'b0;
  logic        prev_lvl, prev_led, exp_led;
  int          run_len, low_cnt, led_err, lead_edges;
  logic [31:0] dec_word;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic push_frame(input logic [31:0] w);
    exp_run_q.push_back('{lvl: 1'b0, len: LM});
    exp_run_q.push_back('{lvl: 1'b1, len: LS});
    for (int i = 0; i < 32; i++) begin
      exp_run_q.push_back('{lvl: 1'b0, len: BM});
      exp_run_q.push_back('{lvl: 1'b1, len: (w[i] ? OS : ZS)});
    end
    exp_run_q.push_back('{lvl: 1'b0, len: BM});
    exp_word_q.push_back(w);
  endtask

  task automatic end_run(input logic lvl, input int len);
    run_t e;
    if (lvl == 1'b1 && low_cnt == 0) return;  // idle or gap
    if (exp_run_q.size() == 0) begin
      check("run_unexpected", len, 0);
    end else begin
      e = exp_run_q.pop_front();
      check($sformatf("run%0d_lvl%0d", low_cnt, lvl),
            (int'(lvl) << 20) | len, (int'(e.lvl) << 20) | e.len);
    end
    if (lvl == 1'b1 && low_cnt >= 2) dec_word[low_cnt-2] = (len > (ZS + OS) / 2);
    if (lvl == 1'b0) begin
      low_cnt++;
      if (low_cnt == 34) begin
        if (exp_word_q.size() == 0) check("word_unexpected", int'(dec_word), 0);
        else check("decoded_word", int'(dec_word), int'(exp_word_q.pop_front()));
        check("lead_led_edges", lead_edges, (LM + 2 * HALF - 1) / (2 * HALF));
        check("led_pattern_errs", led_err, 0);
        low_cnt    = 0;
        lead_edges = 0;
        led_err    = 0;
      end
    end
  endtask

  // Line monitor: run lengths, bit decode and cycle-accurate carrier model.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_lvl   = ifc.ir_txd;
      prev_led   = ifc.ir_led;
      run_len    = 0;
      low_cnt    = 0;
      led_err    = 0;
      lead_edges = 0;
    end else begin
      if (ifc.ir_txd === prev_lvl) run_len++;
      else begin
        if (run_len > 0) end_run(prev_lvl, run_len);
        prev_lvl = ifc.ir_txd;
        run_len  = 1;
      end
      exp_led = (ifc.ir_txd === 1'b0) && ((((run_len - 1) / HALF) % 2) == 0);
      if (ifc.ir_led !== exp_led) led_err++;
      if (ifc.ir_txd === 1'b0 && low_cnt == 0 && ifc.ir_led === 1'b1 && prev_led !== 1'b1)
        lead_edges++;
      prev_led = ifc.ir_led;
    end
  end

  // Called on a negedge where busy should already be high; returns on the done cycle.
  task automatic wait_frame(input string tag, input int exp_busy, input int pulse_at);
    int blen = 0;
    int dcnt = 0;
    int t    = 0;
    while (ifc.busy === 1'b1 && t < LIMIT) begin
      blen++;
      if (pulse_at > 0 && t == pulse_at) ifc.send = 1'b1;
      if (pulse_at > 0 && t == pulse_at + 3) ifc.send = 1'b0;
      @(negedge clk);
      if (ifc.done === 1'b1) dcnt++;
      t++;
    end
    check({tag, "_busy_len"}, blen, exp_busy);
    check({tag, "_done_cnt"}, dcnt, 1);
    check({tag, "_done_at_fall"}, int'(ifc.done), 1);
  endtask

  task automatic send_one(input logic [7:0] key, input logic [31:0] w, input int exp_busy);
    repeat (3) @(negedge clk);
    ifc.key_code = key;
    ifc.send     = 1'b1;
    push_frame(w);
    @(negedge clk);
    ifc.send     = 1'b0;
    ifc.key_code = ~key;
    wait_frame($sformatf("k%02h", key), exp_busy, 0);
  endtask

  initial begin
    vec_t vecs[4];
    int   busy_after;
    vecs[0] = '{key: 8'h45, word: 32'hBA456B86, busy_len: FRAME_BUSY};
    vecs[1] = '{key: 8'h00, word: 32'hFF006B86, busy_len: FRAME_BUSY};
    vecs[2] = '{key: 8'hFF, word: 32'h00FF6B86, busy_len: FRAME_BUSY};
    vecs[3] = '{key: 8'h5A, word: 32'hA55A6B86, busy_len: FRAME_BUSY};

    ifc.send     = 1'b0;
    ifc.key_code = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd",  int'(ifc.ir_txd), 1);
    check("rst_led",  int'(ifc.ir_led), 0);
    check("rst_busy", int'(ifc.busy),   0);
    check("rst_done", int'(ifc.done),   0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 4; i++) send_one(vecs[i].key, vecs[i].word, vecs[i].busy_len);

    // send held high through a frame, re-accepted on the done cycle with a new key
    repeat (3) @(negedge clk);
    ifc.key_code = 8'h45;
    ifc.send     = 1'b1;
    push_frame(32'hBA456B86);
    @(negedge clk);
    wait_frame("held", FRAME_BUSY, 0);
    ifc.key_code = 8'h12;
    push_frame(32'hED126B86);
    @(negedge clk);
    ifc.send = 1'b0;
    check("b2b_busy_gap", int'(ifc.busy), 1);
    wait_frame("b2b", FRAME_BUSY, 200);
    busy_after = 0;
    repeat (60) begin
      @(negedge clk);
      if (ifc.busy === 1'b1) busy_after++;
    end
    check("no_queued_frame", busy_after, 0);

    // reset in the middle of the leader mark
    repeat (3) @(negedge clk);
    ifc.key_code = 8'hA5;
    ifc.send     = 1'b1;
    push_frame(32'h5AA56B86);
    @(negedge clk);
    ifc.send = 1'b0;
    repeat (49) @(negedge clk);
    check("pre_rst_txd", int'(ifc.ir_txd), 0);
    check("pre_rst_led", int'(ifc.ir_led), (((49 / HALF) % 2) == 0) ? 1 : 0);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_txd",  int'(ifc.ir_txd), 1);
    check("midrst_led",  int'(ifc.ir_led), 0);
    check("midrst_busy", int'(ifc.busy),   0);
    check("midrst_done", int'(ifc.done),   0);
    exp_run_q.delete();
    exp_word_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    send_one(8'hC3, 32'h3CC36B86, FRAME_BUSY);

    repeat (5) @(negedge clk);
    check("runs_left",  exp_run_q.size(),  0);
    check("words_left", exp_word_q.size(), 0);
    check("led_tail",   led_err,           0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
